// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller with edge-latched sources,
// a mask register and a REQ/SERVICE/GAP handshake with the core.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-low
//   irq_src    - level interrupt sources (edge-detected internally)
//   mask_wr    - load mask register from mask_data at the next edge
//   mask_data  - new mask, bit=1 enables that source
//   intAck     - core accepted the request (honoured only in REQ)
//   intDone    - handler returned (honoured only in SERVICE)
//   interrupt  - request to the core's interrupt pin
//   vector     - index of the source being requested or serviced
//   pending    - pending latch contents
//   busy       - high whenever the FSM is not IDLE
//
// NUM_SRC must be at least 2.

module interrupt_controller #(
    parameter int NUM_SRC    = 4,
    parameter int GAP_CYCLES = 3
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_SRC-1:0]                         irq_src,
    input  logic                                       mask_wr,
    input  logic [NUM_SRC-1:0]                         mask_data,
    input  logic                                       intAck,
    input  logic                                       intDone,
    output logic                                       interrupt,
    output logic [(NUM_SRC > 1 ? $clog2(NUM_SRC) : 1)-1:0] vector,
    output logic [NUM_SRC-1:0]                         pending,
    output logic                                       busy
);

    localparam int VW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] GAP_LOAD =
        (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE,
        GAP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] prev;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr;
    logic [VW-1:0]      winner;
    logic [VW-1:0]      vector_next;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_next;

    assign rise     = irq_src & ~prev;
    assign eligible = pending & mask;

    // Scan high to low so the lowest eligible index is the last write.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = VW'(i);
            end
        end
    end

    always_comb begin
        state_next  = state;
        vector_next = vector;
        cnt_next    = cnt;
        clr         = '0;
        unique case (state)
            IDLE: begin
                if (|eligible) begin
                    state_next  = REQ;
                    vector_next = winner;
                end
            end
            REQ: begin
                if (intAck) begin
                    state_next  = SERVICE;
                    clr[vector] = 1'b1;
                end
            end
            SERVICE: begin
                if (intDone) begin
                    if (GAP_CYCLES == 0) begin
                        state_next = IDLE;
                    end else begin
                        state_next = GAP;
                        cnt_next   = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // prev tracks irq_src even through reset so held levels give no edge.
    // A new edge on the same cycle as an ack clear wins (set after clear).
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            vector  <= '0;
            cnt     <= '0;
            pending <= '0;
            mask    <= '1;
            prev    <= irq_src;
        end else begin
            state   <= state_next;
            vector  <= vector_next;
            cnt     <= cnt_next;
            pending <= (pending & ~clr) | rise;
            prev    <= irq_src;
            if (mask_wr) begin
                mask <= mask_data;
            end
        end
    end

    assign interrupt = (state == REQ);
    assign busy      = (state != IDLE);

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter NUM_SRC, default 4: number of interrupt sources.
REQ-002 Parameter GAP_CYCLES, default 3: number of idle cycles after a service completes before the next request.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port irq_src, input, NUM_SRC bits: level interrupt sources, sampled each cycle.
REQ-006 Port mask_wr, input, 1 bit: write enable for the mask register.
REQ-007 Port mask_data, input, NUM_SRC bits: new mask value; bit=1 enables that source.
REQ-008 Port intAck, input, 1 bit: one-cycle pulse from the core when it accepts the interrupt.
REQ-009 Port intDone, input, 1 bit: one-cycle pulse from the core when the handler returns (RTI retired).
REQ-010 Port interrupt, output, 1 bit: request to the core's interrupt pin.
REQ-011 Port vector, output, clog2(NUM_SRC) bits: index of the source being requested or serviced.
REQ-012 Port pending, output, NUM_SRC bits: pending latch contents.
REQ-013 Port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 Rising-edge detect per source: the pending bit sets when irq_src[i] is 1 this cycle and its registered previous value is 0.
REQ-015 A pending bit is held until it is cleared by an acknowledge; repeated edges while the bit is set are absorbed and not counted.
REQ-016 Eligible set = pending & mask; masked pending bits are retained and become eligible once unmasked.
REQ-017 Fixed priority: the lowest eligible index wins.
REQ-018 The FSM has four states: IDLE, REQ, SERVICE and GAP.
REQ-019 IDLE→REQ on the cycle after the eligible set is nonzero; the winner is registered into vector on entry.
REQ-020 In REQ, interrupt=1 and vector is held stable; a source with a higher priority arriving in REQ does not change vector.
REQ-021 REQ→SERVICE on intAck=1; the same edge clears pending[vector] and interrupt falls in the next cycle.
REQ-022 In SERVICE, interrupt=0 and vector is held; SERVICE→GAP on intDone=1.
REQ-023 GAP loads a down-counter with GAP_CYCLES-1 and returns to IDLE when it reaches 0, giving exactly GAP_CYCLES cycles in GAP.
REQ-024 If GAP_CYCLES=0, SERVICE goes directly to IDLE.
REQ-025 intAck outside REQ is ignored, and intDone outside SERVICE is ignored.
REQ-026 An edge on the serviced source during SERVICE or GAP sets its pending bit again, and it is serviced later.
REQ-027 If an edge and an ack clear of the same bit occur on the same cycle, set wins and the bit remains 1.
REQ-028 mask_wr takes effect at the next edge.
REQ-029 Masking the vectored source while in REQ does not withdraw the request; the request completes normally.
REQ-030 Minimum latency is 2 cycles from the source edge to interrupt=1: edge registered, then REQ entry.

Reset
REQ-031 When reset=0 at a clock edge, the block SHALL set state=IDLE, interrupt=0, vector=0, pending=0, busy=0, gap counter=0 and mask=all ones.
REQ-032 On the same reset edge, the block SHALL load the previous-irq register with the current irq_src, so that levels held through reset produce no edge.
REQ-033 Reset asserted mid-REQ or mid-SERVICE SHALL abort immediately, with no partial clear of other pending bits surviving.

Verification
REQ-034 Single source: irq_src[2] 0→1, mask=4'hF → pending=4'b0100, then interrupt=1 with vector=2 two cycles after the edge; intAck → pending=0, interrupt=0 next cycle.
REQ-035 Priority: edges on sources 3 and 1 on the same cycle → vector=1 first; after intDone plus 3 GAP cycles, a second request with vector=3.
REQ-036 Mask: mask=4'b1110, edge on source 0 → pending=4'b0001, interrupt stays 0; writing mask=4'hF → interrupt=1 with vector=0.
REQ-037 Re-arm: an edge on source 2 during SERVICE of source 2 → pending[2]=1 after the ack; a second request after GAP; stray intAck in IDLE produces no state change.
REQ-038 Reset: reset=0 while in SERVICE with pending=4'b1010 → next cycle interrupt=0, busy=0, pending=0, mask=4'hF; a source held at 1 through reset raises no request.
